// File: rtl/alu_writeback_stage.sv
// Registered ALU/branch writeback stage with taken-branch redirect and squash window.
// Optional `ifdef PERF_COUNTERS_EN adds perf_clr/perf_taken/perf_squashed counters.
module alu_writeback_stage #(
  parameter int          DATA_W        = 32,
  parameter int          OPCODE_W      = 5,
  parameter logic [OPCODE_W-1:0] BRANCH_OPCODE = 5'b10001,
  parameter int          FLUSH_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              cond_pass,
  input  logic              wb_request,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wb_en,
  output logic              out_is_branch,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush_active
`ifdef PERF_COUNTERS_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_taken,
  output logic [31:0]       perf_squashed
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_wb_en_q, out_wb_en_d;
  logic              out_is_branch_q, out_is_branch_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  logic accept;
  logic taken;
  logic squash;
  logic taken_acc;

  // In FLUSH nothing is written to the output register, so input never stalls.
  assign in_ready  = (state_q == FLUSH) || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign taken     = (opcode == BRANCH_OPCODE) && cond_pass;
  assign squash    = accept && (state_q == FLUSH);
  assign taken_acc = accept && (state_q == RUN) && taken;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    out_valid_d      = out_valid_q && !out_ready;
    out_data_d       = out_data_q;
    out_wb_en_d      = out_wb_en_q;
    out_is_branch_d  = out_is_branch_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          if (taken) begin
            out_data_d       = branch_target;
            out_is_branch_d  = 1'b1;
            out_wb_en_d      = wb_request;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = branch_target;
            if (FLUSH_CYCLES > 0) begin
              state_d = FLUSH;
              cnt_d   = CNT_W'(FLUSH_CYCLES);
            end
          end else begin
            out_data_d      = alu_result;
            out_is_branch_d = 1'b0;
            out_wb_en_d     = wb_request && cond_pass;
          end
        end
      end
      FLUSH: begin
        if (squash) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      cnt_q            <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_wb_en_q      <= 1'b0;
      out_is_branch_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_wb_en_q      <= out_wb_en_d;
      out_is_branch_q  <= out_is_branch_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_wb_en      = out_wb_en_q;
  assign out_is_branch  = out_is_branch_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_active   = (state_q == FLUSH);

`ifdef PERF_COUNTERS_EN
  logic [31:0] perf_taken_q, perf_taken_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    perf_taken_d    = perf_taken_q + {31'd0, taken_acc};
    perf_squashed_d = perf_squashed_q + {31'd0, squash};
    if (perf_clr) begin
      perf_taken_d    = '0;
      perf_squashed_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_taken_q    <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_taken_q    <= perf_taken_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_taken    = perf_taken_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage (default FLUSH_CYCLES=2).
// Perf counter checks compile only when PERF_COUNTERS_EN is defined.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [31:0] alu_result;
  logic [31:0] branch_target;
  logic        cond_pass;
  logic        wb_request;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_wb_en;
  logic        out_is_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_active;
`ifdef PERF_COUNTERS_EN
  logic        perf_clr;
  logic [31:0] perf_taken;
  logic [31:0] perf_squashed;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_result(alu_result), .branch_target(branch_target),
    .cond_pass(cond_pass), .wb_request(wb_request), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_wb_en(out_wb_en),
    .out_is_branch(out_is_branch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_active(flush_active)
`ifdef PERF_COUNTERS_EN
    , .perf_clr(perf_clr), .perf_taken(perf_taken), .perf_squashed(perf_squashed)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] alu,
                       input logic [31:0] tgt, input logic cp, input logic wb);
    in_valid = v; opcode = op; alu_result = alu; branch_target = tgt;
    cond_pass = cp; wb_request = wb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef PERF_COUNTERS_EN
    perf_clr = 1'b0;
`endif
    #12;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'd0) $display("FAIL reset_out_data: got %h exp 0", out_data); else n_pass++;
    n_chk++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) $display("FAIL reset_redirect: got %b/%h exp 0/0", redirect_valid, redirect_pc); else n_pass++;
    n_chk++; if (flush_active !== 1'b0) $display("FAIL reset_flush: got %b exp 0", flush_active); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_alu_op();
    drive(1'b1, 5'b00100, 32'h1234, 32'h0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL alu_valid: got %b exp 1", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'h1234) $display("FAIL alu_data: got %h exp 1234", out_data); else n_pass++;
    n_chk++; if (out_wb_en !== 1'b1 || out_is_branch !== 1'b0) $display("FAIL alu_flags: got wb=%b br=%b exp 1/0", out_wb_en, out_is_branch); else n_pass++;
    n_chk++; if (redirect_valid !== 1'b0) $display("FAIL alu_redirect: got %b exp 0", redirect_valid); else n_pass++;
    cyc();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL alu_drain: got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_taken_branch_flush();
    drive(1'b1, 5'b10001, 32'hDEAD, 32'h80, 1'b1, 1'b0);
    cyc();
    n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) $display("FAIL br_redirect: got %b/%h exp 1/80", redirect_valid, redirect_pc); else n_pass++;
    n_chk++; if (out_data !== 32'h80 || out_is_branch !== 1'b1 || out_wb_en !== 1'b0) $display("FAIL br_out: got %h br=%b wb=%b exp 80/1/0", out_data, out_is_branch, out_wb_en); else n_pass++;
    n_chk++; if (flush_active !== 1'b1) $display("FAIL br_flush_on: got %b exp 1", flush_active); else n_pass++;
    drive(1'b1, 5'b00100, 32'h1111, 32'h0, 1'b1, 1'b1);
    cyc();
    n_chk++; if (redirect_valid !== 1'b0) $display("FAIL br_pulse_one: got %b exp 0", redirect_valid); else n_pass++;
    n_chk++; if (out_valid !== 1'b0 || flush_active !== 1'b1) $display("FAIL br_squash1: got v=%b f=%b exp 0/1", out_valid, flush_active); else n_pass++;
    drive(1'b1, 5'b00100, 32'h2222, 32'h0, 1'b1, 1'b1);
    cyc();
    n_chk++; if (out_valid !== 1'b0 || flush_active !== 1'b0) $display("FAIL br_squash2: got v=%b f=%b exp 0/0", out_valid, flush_active); else n_pass++;
    drive(1'b1, 5'b00100, 32'h3333, 32'h0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h3333) $display("FAIL br_third: got v=%b d=%h exp 1/3333", out_valid, out_data); else n_pass++;
    cyc();
  endtask

  task automatic test_not_taken();
    drive(1'b1, 5'b10001, 32'h55, 32'h99, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_data !== 32'h55 || out_wb_en !== 1'b0 || out_is_branch !== 1'b0) $display("FAIL nt_out: got %h wb=%b br=%b exp 55/0/0", out_data, out_wb_en, out_is_branch); else n_pass++;
    n_chk++; if (redirect_valid !== 1'b0 || flush_active !== 1'b0) $display("FAIL nt_state: got r=%b f=%b exp 0/0", redirect_valid, flush_active); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 5'b00100, 32'hAAAA, 32'h0, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'b00100, 32'hBBBB, 32'h0, 1'b1, 1'b1);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b exp 0", in_ready); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_chk++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA) $display("FAIL bp_hold%0d: got v=%b d=%h exp 1/aaaa", i, out_valid, out_data); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b exp 1", in_ready); else n_pass++;
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 32'hBBBB) $display("FAIL bp_refill: got v=%b d=%h exp 1/bbbb", out_valid, out_data); else n_pass++;
    cyc();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush_hold();
    out_ready = 1'b0;
    drive(1'b1, 5'b10001, 32'h0, 32'h440, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'b00100, 32'h5151, 32'h0, 1'b1, 1'b1);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL fh_in_ready: got %b exp 1", in_ready); else n_pass++;
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h440 || out_wb_en !== 1'b1) $display("FAIL fh_hold: got v=%b d=%h wb=%b exp 1/440/1", out_valid, out_data, out_wb_en); else n_pass++;
    cyc();
    n_chk++; if (flush_active !== 1'b1) $display("FAIL fh_idle_no_dec: got %b exp 1", flush_active); else n_pass++;
    drive(1'b1, 5'b10001, 32'h0, 32'h999, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (flush_active !== 1'b0 || redirect_valid !== 1'b0 || out_data !== 32'h440) $display("FAIL fh_branch_squash: got f=%b r=%b d=%h exp 0/0/440", flush_active, redirect_valid, out_data); else n_pass++;
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_flush();
    out_ready = 1'b0;
    drive(1'b1, 5'b10001, 32'h0, 32'h700, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'b00100, 32'h1, 32'h0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (flush_active !== 1'b1 || out_valid !== 1'b1) $display("FAIL rf_pre: got f=%b v=%b exp 1/1", flush_active, out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_wb_en !== 1'b0 || out_is_branch !== 1'b0) $display("FAIL rf_async_out: got v=%b d=%h wb=%b br=%b exp 0", out_valid, out_data, out_wb_en, out_is_branch); else n_pass++;
    n_chk++; if (flush_active !== 1'b0 || redirect_pc !== 32'd0) $display("FAIL rf_async_state: got f=%b pc=%h exp 0/0", flush_active, redirect_pc); else n_pass++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    drive(1'b1, 5'b00100, 32'h77, 32'h0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h77) $display("FAIL rf_after: got v=%b d=%h exp 1/77", out_valid, out_data); else n_pass++;
    cyc();
  endtask

`ifdef PERF_COUNTERS_EN
  task automatic test_perf();
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 5'b10001, 32'h0, 32'h100, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 5'b00100, 32'h1, 32'h0, 1'b1, 1'b1);
      cyc();
      cyc();
    end
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (perf_taken !== 32'd3 || perf_squashed !== 32'd6) $display("FAIL perf_counts: got %0d/%0d exp 3/6", perf_taken, perf_squashed); else n_pass++;
    drive(1'b1, 5'b10001, 32'h0, 32'h200, 1'b1, 1'b0);
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++; if (perf_taken !== 32'd0 || perf_squashed !== 32'd0) $display("FAIL perf_clr_wins: got %0d/%0d exp 0/0", perf_taken, perf_squashed); else n_pass++;
    drive(1'b1, 5'b00100, 32'h1, 32'h0, 1'b1, 1'b1);
    cyc();
    cyc();
    drive(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_taken_branch_flush();
    test_not_taken();
    test_back_to_back();
    test_flush_hold();
    test_reset_mid_flush();
`ifdef PERF_COUNTERS_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

endmodule
